grf_write_sched: RTL and testbench

GRF_WRITE_SCHED -- requirements
Module: grf_write_sched

---
 rtl/grf_write_sched.sv | 148 ++++++++++++++
 tb/tb_grf_write_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_write_sched.sv
// grf_write_sched: schedules the single register-file write port between
// the pipeline writeback and long-latency aux results (MDU / load return).
// Writeback always wins. Aux results wait in a 2-entry FIFO and drain in
// free slots. A pending scoreboard tracks registers that still await an aux
// result, and a starvation counter asks the pipeline to back off when the
// FIFO head has been blocked for too long.
module grf_write_sched #(
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        aux_valid,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    input  logic [31:0] aux_pc,
    output logic        aux_ready,
    input  logic        sb_set,
    input  logic [4:0]  sb_addr,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic        wb_stall
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    // Two-entry aux FIFO kept as a shift register: slot 0 is always the head.
    logic [4:0]    r_fifoAddr [2];
    logic [31:0]   r_fifoData [2];
    logic [31:0]   r_fifoPc   [2];
    logic [1:0]    r_count;

    logic [31:0]   r_pending;
    logic [CW-1:0] r_starve;
    logic          r_stall;

    logic          r_grfWe;
    logic [4:0]    r_grfA3;
    logic [31:0]   r_grfWd;
    logic [31:0]   r_grfPc;

    logic          w_auxReady;
    logic          w_wbReq;
    logic          w_pop;
    logic          w_push;
    logic          w_pushIdx;
    logic [31:0]   w_pendNext;
    logic [CW-1:0] w_starveNext;

    // Readiness only looks at occupancy, never at a same-cycle pop.
    assign w_auxReady = (r_count != 2'd2);
    assign aux_ready  = w_auxReady;
    assign q_busy1    = r_pending[q_a1];
    assign q_busy2    = r_pending[q_a2];
    assign grf_we     = r_grfWe;
    assign grf_a3     = r_grfA3;
    assign grf_wd     = r_grfWd;
    assign grf_pc     = r_grfPc;
    assign wb_stall   = r_stall;

    // Arbitration, FIFO slot selection, next pending vector and starvation count.
    always_comb begin
        w_wbReq      = wb_we && (wb_addr != 5'd0);
        w_pop        = !w_wbReq && (r_count != 2'd0);
        w_push       = aux_valid && w_auxReady && (aux_addr != 5'd0);
        // With a pop the tail moves down one slot, so the new entry lands one lower.
        w_pushIdx    = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);

        w_pendNext   = r_pending;
        if (w_pop) begin
            w_pendNext[r_fifoAddr[0]] = 1'b0;
        end
        if (sb_set && (sb_addr != 5'd0)) begin
            w_pendNext[sb_addr] = 1'b1;
        end

        w_starveNext = r_starve;
        if ((r_count == 2'd0) || w_pop) begin
            w_starveNext = '0;
        end else if (r_starve != LIM) begin
            w_starveNext = r_starve + 1'b1;
        end
    end

    // FIFO storage: shift on pop, then write the pushed entry (may overwrite the shifted slot).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_fifoAddr[0] <= r_fifoAddr[1];
                r_fifoData[0] <= r_fifoData[1];
                r_fifoPc[0]   <= r_fifoPc[1];
            end
            if (w_push) begin
                r_fifoAddr[w_pushIdx] <= aux_addr;
                r_fifoData[w_pushIdx] <= aux_data;
                r_fifoPc[w_pushIdx]   <= aux_pc;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Scoreboard and starvation state; stall mirrors the counter sitting at its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
        end else begin
            r_pending <= w_pendNext;
            r_starve  <= w_starveNext;
            r_stall   <= (w_starveNext == LIM);
        end
    end

    // Registered GRF write port; address/data/pc hold when no write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grfWe <= 1'b0;
            r_grfA3 <= 5'd0;
            r_grfWd <= 32'd0;
            r_grfPc <= 32'd0;
        end else begin
            r_grfWe <= w_wbReq || w_pop;
            if (w_wbReq) begin
                r_grfA3 <= wb_addr;
                r_grfWd <= wb_data;
                r_grfPc <= wb_pc;
            end else if (w_pop) begin
                r_grfA3 <= r_fifoAddr[0];
                r_grfWd <= r_fifoData[0];
                r_grfPc <= r_fifoPc[0];
            end
        end
    end

endmodule

// File: tb/tb_grf_write_sched.sv
// Testbench for grf_write_sched: a behavioural queue model predicts each
// cycle's GRF write, pushes it to a scoreboard when stimulus is driven and
// compares it after the clock edge; table vectors and directed sequences
// add explicit constant expectations for the corner cases.
module tb_grf_write_sched;

    localparam int LIM = 8;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        stall;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } aux_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        expWe;
        logic [4:0]  expA3;
        logic [31:0] expWd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        aux_valid = 1'b0;
    logic [4:0]  aux_addr = '0;
    logic [31:0] aux_data = '0;
    logic [31:0] aux_pc = '0;
    logic        aux_ready;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic [4:0]  q_a1 = '0;
    logic [4:0]  q_a2 = '0;
    logic        q_busy1, q_busy2;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic        wb_stall;

    int checks = 0;
    int failures = 0;

    exp_t        expQ[$];
    aux_t        mQ[$];
    logic [31:0] mPend = '0;
    int          mStarve = 0;
    exp_t        mLast = '{default: '0};
    vec_t        vecs[6];

    grf_write_sched #(.STARVE_LIM(LIM)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data), .aux_pc(aux_pc),
        .aux_ready(aux_ready),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pop the scoreboard entry for the edge just taken and compare all outputs.
    task automatic checkOutput();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        checks--;
        e = expQ.pop_front();
        checkVal("grf_we", grf_we, e.we);
        checkVal("grf_a3", grf_a3, e.a3);
        checkVal("grf_wd", grf_wd, e.wd);
        checkVal("grf_pc", grf_pc, e.pc);
        checkVal("wb_stall", wb_stall, e.stall);
        checkVal("q_busy1", q_busy1, mPend[q_a1]);
        checkVal("q_busy2", q_busy2, mPend[q_a2]);
    endtask

    // Drive one cycle of stimulus, predict the outcome, take the edge, check.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [31:0] wp, input logic av, input logic [4:0] aa,
                                 input logic [31:0] ad, input logic [31:0] ap,
                                 input logic ss, input logic [4:0] sa);
        exp_t e;
        aux_t h;
        logic wbReq, pop, rdy;
        wb_we = we; wb_addr = wa; wb_data = wd; wb_pc = wp;
        aux_valid = av; aux_addr = aa; aux_data = ad; aux_pc = ap;
        sb_set = ss; sb_addr = sa;
        #1;
        rdy = (mQ.size() < 2);
        checkVal("aux_ready", aux_ready, rdy);
        wbReq = we && (wa != 5'd0);
        pop = !wbReq && (mQ.size() > 0);
        e = mLast;
        e.we = 1'b0;
        if (wbReq) begin
            e.we = 1'b1; e.a3 = wa; e.wd = wd; e.pc = wp;
        end else if (pop) begin
            h = mQ[0];
            e.we = 1'b1; e.a3 = h.addr; e.wd = h.data; e.pc = h.pc;
            mPend[h.addr] = 1'b0;
        end
        if (ss && (sa != 5'd0)) mPend[sa] = 1'b1;
        if ((mQ.size() == 0) || pop) mStarve = 0;
        else if (mStarve < LIM) mStarve++;
        e.stall = (mStarve == LIM);
        if (pop) h = mQ.pop_front();
        if (av && rdy && (aa != 5'd0)) mQ.push_back('{aa, ad, ap});
        mLast = e;
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset while requests of every kind are active; nothing may survive it.
    task automatic doReset();
        reset = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hBAD0; wb_pc = 32'h44;
        aux_valid = 1'b1; aux_addr = 5'd6; aux_data = 32'hBAD1; aux_pc = 32'h48;
        sb_set = 1'b1; sb_addr = 5'd7;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wb_we = 1'b0; aux_valid = 1'b0; sb_set = 1'b0;
        mQ.delete(); expQ.delete();
        mPend = '0; mStarve = 0; mLast = '{default: '0};
        checkVal("rst_grf_we", grf_we, 0);
        checkVal("rst_grf_a3", grf_a3, 0);
        checkVal("rst_grf_wd", grf_wd, 0);
        checkVal("rst_grf_pc", grf_pc, 0);
        checkVal("rst_wb_stall", wb_stall, 0);
        checkVal("rst_aux_ready", aux_ready, 1);
        checkVal("rst_q_busy1", q_busy1, 0);
        checkVal("rst_q_busy2", q_busy2, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h1234,     32'h100, 1'b1, 5'd5,  32'h1234};
        vecs[1] = '{1'b1, 5'd0,  32'hDEAD,     32'h104, 1'b0, 5'd5,  32'h1234};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 32'h108, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[3] = '{1'b0, 5'd7,  32'h55,       32'h10C, 1'b0, 5'd31, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd1,  32'h0,        32'h110, 1'b1, 5'd1,  32'h0};
        vecs[5] = '{1'b1, 5'd1,  32'hA5A5A5A5, 32'h114, 1'b1, 5'd1,  32'hA5A5A5A5};

        @(negedge clk);
        doReset();
        idle(1);

        // Single-cycle writeback vectors.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].pc, 0, 0, 0, 0, 0, 0);
            checkVal("vec_we", grf_we, vecs[i].expWe);
            checkVal("vec_a3", grf_a3, vecs[i].expA3);
            checkVal("vec_wd", grf_wd, vecs[i].expWd);
        end

        // Scoreboard set, aux push, drain two cycles later clears busy.
        q_a1 = 5'd8;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
        checkVal("sb_r8_busy", q_busy1, 1);
        applyStimulus(0, 0, 0, 0, 1, 8, 32'hAA, 32'h200, 0, 0);
        checkVal("aux_r8_wait_we", grf_we, 0);
        checkVal("aux_r8_wait_busy", q_busy1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("aux_r8_we", grf_we, 1);
        checkVal("aux_r8_a3", grf_a3, 8);
        checkVal("aux_r8_wd", grf_wd, 32'hAA);
        checkVal("aux_r8_busy_clr", q_busy1, 0);

        // aux to r0 is discarded; bit 0 never becomes busy.
        q_a2 = 5'd0;
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h77, 32'h204, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("aux_r0_dropped", grf_we, 0);
        checkVal("r0_never_busy", q_busy2, 0);

        // wb_we with addr 0 leaves the slot to the FIFO head.
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h99, 32'h208, 0, 0);
        applyStimulus(1, 0, 32'hDEAD, 32'h20C, 0, 0, 0, 0, 0, 0);
        checkVal("wb_r0_head_a3", grf_a3, 9);

        // Fill the FIFO under wb pressure until stall, then drain in order.
        applyStimulus(1, 10, 32'h1010, 32'h300, 1, 1, 32'h11, 32'h310, 0, 0);
        applyStimulus(1, 11, 32'h1111, 32'h304, 1, 2, 32'h22, 32'h314, 0, 0);
        for (int i = 2; i <= LIM; i++) begin
            applyStimulus(1, 12, 32'h1200 + i, 32'h308, 1, 3, 32'h33, 32'h318, 0, 0);
            checkVal("full_aux_ready", aux_ready, 0);
            if (i == LIM - 1) checkVal("stall_before_lim", wb_stall, 0);
        end
        checkVal("stall_at_lim", wb_stall, 1);
        applyStimulus(1, 13, 32'h1313, 32'h30C, 1, 3, 32'h33, 32'h318, 0, 0);
        checkVal("stall_wb_wins_a3", grf_a3, 13);
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h33, 32'h318, 0, 0);
        checkVal("drain1_a3", grf_a3, 1);
        checkVal("stall_cleared", wb_stall, 0);
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h33, 32'h318, 0, 0);
        checkVal("drain2_a3", grf_a3, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("drain3_a3", grf_a3, 3);
        checkVal("drain3_wd", grf_wd, 32'h33);
        idle(1);

        // Set and drain of the same register in one cycle: set wins.
        q_a2 = 5'd4;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 1, 4, 32'h44, 32'h400, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        checkVal("r4_drained", grf_a3, 4);
        checkVal("r4_set_wins", q_busy2, 1);
        idle(1);

        // Reset with FIFO full and pending nonzero.
        q_a1 = 5'd5;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        applyStimulus(1, 14, 32'h1414, 32'h500, 1, 5, 32'h55, 32'h510, 0, 0);
        applyStimulus(1, 15, 32'h1515, 32'h504, 1, 6, 32'h66, 32'h514, 0, 0);
        checkVal("pre_rst_full", aux_ready, 0);
        doReset();
        idle(3);
        checkVal("post_rst_no_write", grf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
